// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer on the data-memory bus.
// The CPU loads PRESET and CTRL. The timer counts COUNT down from PRESET
// and raises an interrupt request toward CP0.
//
// Ports:
//   Clk   - system clock, rising edge
//   Reset - synchronous active-low reset (0 = reset)
//   Addr  - word offset within the timer window (CPU address bits [3:2])
//   WE    - word write strobe, already qualified by chip select
//   DIN   - write data
//   DOUT  - read data, combinational from Addr
//   IRQ   - interrupt request (IM & irq flag)
//
// Register map: 0 CTRL {IM, Mode[1:0], En}, 1 PRESET, 2 COUNT (read-only),
// 3 reads zero. Writes to offsets 2 and 3 are ignored.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_flag;

  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic             ctrl_wr;
  logic             preset_wr;

  logic             load_count;
  logic             dec_count;
  logic             zero_count;
  logic             set_irq;
  logic             clr_irq_fsm;
  logic             clr_en;

  assign en        = ctrl[0];
  assign mode      = ctrl[2:1];
  assign im        = ctrl[3];
  assign ctrl_wr   = WE && (Addr == 2'd0);
  assign preset_wr = WE && (Addr == 2'd1);

  // Next-state logic and datapath strobes. Only Mode 1 auto-reloads.
  // Reserved modes 2 and 3 fall into the one-shot path.
  always_comb begin
    state_next  = state;
    load_count  = 1'b0;
    dec_count   = 1'b0;
    zero_count  = 1'b0;
    set_irq     = 1'b0;
    clr_irq_fsm = 1'b0;
    clr_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_count  = 1'b1;
        clr_irq_fsm = 1'b1;
        state_next  = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (count > CNT_W'(1)) begin
          dec_count = 1'b1;
        end else begin
          // Both 1 and 0 finish here. This keeps COUNT from wrapping,
          // and a PRESET of 0 times out like a PRESET of 1.
          zero_count = 1'b1;
          set_irq    = 1'b1;
          state_next = ST_INT;
        end
      end
      ST_INT: begin
        state_next = ST_IDLE;
        if (mode == 2'd1) clr_irq_fsm = 1'b1;
        else              clr_en      = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A bus write to CTRL overrides the one-shot En clear.
  // Setting the irq flag overrides any clear that lands on the same edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (ctrl_wr)     ctrl    <= DIN[3:0];
      else if (clr_en) ctrl[0] <= 1'b0;

      if (preset_wr) preset <= DIN[CNT_W-1:0];

      if (load_count)      count <= preset;
      else if (dec_count)  count <= count - CNT_W'(1);
      else if (zero_count) count <= '0;

      if (set_irq)                                   irq_flag <= 1'b1;
      else if (ctrl_wr || preset_wr || clr_irq_fsm)  irq_flag <= 1'b0;
    end
  end

  assign IRQ = im & irq_flag;

  // Read mux. Registers narrower than the bus are zero-extended.
  always_comb begin
    DOUT = '0;
    case (Addr)
      2'd0:    DOUT[3:0]       = ctrl;
      2'd1:    DOUT[CNT_W-1:0] = preset;
      2'd2:    DOUT[CNT_W-1:0] = count;
      default: DOUT            = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed self-checking bench for timer_dev.
// Inputs change 1 ns after a rising edge. Outputs are sampled between edges.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int tests = 0;
  int fails = 0;

  timer_dev #(.CNT_W(32)) dut (
    .Clk(clk),
    .Reset(reset),
    .Addr(addr),
    .WE(we),
    .DIN(din),
    .DOUT(dout),
    .IRQ(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus write. It takes effect at the next rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
    din  = 32'h0;
  endtask

  // Combinational read of the register selected by a.
  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bus_write(2'd1, 32'h1234);
    bus_write(2'd0, 32'hF);
    step(5);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    for (int a = 0; a < 3; a++) begin
      read_reg(2'(a), d);
      tests++;
      if (d !== 32'h0) begin
        fails++;
        $display("[TB] FAIL reset_reg%0d: got %0h expected 0", a, d);
      end
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    step(4);
    read_reg(2'd2, d);
    tests++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_idle: count %0h irq %b expected 0 0", d, irq);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    step(2);
    for (int i = 0; i < 5; i++) begin
      read_reg(2'd2, d);
      tests++;
      if (d !== 32'(5 - i) || irq !== 1'b0) begin
        fails++;
        $display("[TB] FAIL oneshot_count%0d: count %0h irq %b expected %0h 0", i, d, irq, 5 - i);
      end
      step(1);
    end
    read_reg(2'd2, d);
    tests++;
    if (d !== 32'h0 || irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL oneshot_expire: count %0h irq %b expected 0 1", d, irq);
    end
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'h9) begin
      fails++;
      $display("[TB] FAIL oneshot_ctrl_before: got %0h expected 9", d);
    end
    step(1);
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'h8 || irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL oneshot_en_clear: ctrl %0h irq %b expected 8 1", d, irq);
    end
    step(3);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL oneshot_hold: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h0);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL oneshot_ack: got %b expected 0", irq);
    end
  endtask

  task automatic test_autoreload;
    logic [31:0] d;
    logic        exp;
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    for (int i = 1; i <= 18; i++) begin
      step(1);
      exp = (i >= 5) && (((i - 5) % 6) == 0);
      tests++;
      if (irq !== exp) begin
        fails++;
        $display("[TB] FAIL autoreload_irq_e%0d: got %b expected %b", i, irq, exp);
      end
    end
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'hB) begin
      fails++;
      $display("[TB] FAIL autoreload_ctrl: got %0h expected b", d);
    end
    bus_write(2'd0, 32'h0);
    step(3);
  endtask

  task automatic test_disable_midcount;
    logic [31:0] d;
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);
    step(5);
    read_reg(2'd2, d);
    tests++;
    if (d !== 32'd7) begin
      fails++;
      $display("[TB] FAIL disable_pre: got %0h expected 7", d);
    end
    bus_write(2'd0, 32'h8);
    step(4);
    read_reg(2'd2, d);
    tests++;
    if (d !== 32'd6 || irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL disable_frozen: count %0h irq %b expected 6 0", d, irq);
    end
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'h9);
    step(2);
    read_reg(2'd2, d);
    tests++;
    if (d !== 32'd4) begin
      fails++;
      $display("[TB] FAIL disable_reload: got %0h expected 4", d);
    end
    step(4);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL disable_reenable_irq: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h0);
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL disable_ack: ctrl %0h irq %b expected 0 0", d, irq);
    end
  endtask

  task automatic test_preset_zero;
    logic [31:0] d;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    step(2);
    read_reg(2'd2, d);
    tests++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_load: count %0h irq %b expected 0 0", d, irq);
    end
    step(1);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL zero_expire: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h0);
    bus_write(2'd0, 32'h1);
    step(3);
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'h1 || irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_masked: ctrl %0h irq %b expected 1 0", d, irq);
    end
    step(1);
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_en_clear: ctrl %0h irq %b expected 0 0", d, irq);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h9);
    step(4);
    bus_write(2'd1, 32'd7);
    read_reg(2'd2, d);
    tests++;
    if (irq !== 1'b1 || d !== 32'h0) begin
      fails++;
      $display("[TB] FAIL set_wins: irq %b count %0h expected 1 0", irq, d);
    end
    step(1);
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'h8 || irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL set_wins_after: ctrl %0h irq %b expected 8 1", d, irq);
    end
    read_reg(2'd1, d);
    tests++;
    if (d !== 32'd7) begin
      fails++;
      $display("[TB] FAIL set_wins_preset: got %0h expected 7", d);
    end
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h9);
    step(3);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL buswin_expire: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'hD);
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'hD || irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL buswin_ctrl: ctrl %0h irq %b expected d 0", d, irq);
    end
    step(3);
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'hD || irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mode2_expire: ctrl %0h irq %b expected d 1", d, irq);
    end
    step(1);
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'hC || irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mode2_oneshot: ctrl %0h irq %b expected c 1", d, irq);
    end
    bus_write(2'd0, 32'h0);
    step(2);
  endtask

  task automatic test_readonly_writes;
    logic [31:0] d;
    bus_write(2'd1, 32'd9);
    bus_write(2'd0, 32'h9);
    step(4);
    bus_write(2'd0, 32'h8);
    step(2);
    bus_write(2'd2, 32'hFFFFFFFF);
    read_reg(2'd2, d);
    tests++;
    if (d !== 32'd6) begin
      fails++;
      $display("[TB] FAIL ro_count_frozen: got %0h expected 6", d);
    end
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h9);
    step(6);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ro_setup_irq: got %b expected 1", irq);
    end
    bus_write(2'd2, 32'hFFFFFFFF);
    read_reg(2'd2, d);
    tests++;
    if (d !== 32'h0 || irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ro_addr2: count %0h irq %b expected 0 1", d, irq);
    end
    bus_write(2'd3, 32'hFFFFFFFF);
    read_reg(2'd3, d);
    tests++;
    if (d !== 32'h0 || irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ro_addr3: read %0h irq %b expected 0 1", d, irq);
    end
    read_reg(2'd1, d);
    tests++;
    if (d !== 32'd2) begin
      fails++;
      $display("[TB] FAIL ro_preset: got %0h expected 2", d);
    end
    read_reg(2'd0, d);
    tests++;
    if (d !== 32'h8) begin
      fails++;
      $display("[TB] FAIL ro_ctrl: got %0h expected 8", d);
    end
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    din   = 32'h0;
    step(2);
    reset = 1'b1;
    step(1);
    test_reset;
    test_oneshot;
    test_autoreload;
    test_disable_midcount;
    test_preset_zero;
    test_back_to_back;
    test_readonly_writes;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
